// File: rtl/arf_rat_pkg.sv
// Shared widths and types for the architectural register file / rename alias table.
// Optional same-cycle retire forwarding is enabled by defining ARF_RAT_BYPASS_EN.
package arf_rat_pkg;

    localparam int unsigned ARF_ID_WIDTH   = 5;
    localparam int unsigned ROB_ID_WIDTH   = 5;
    localparam int unsigned REG_DATA_WIDTH = 32;

    typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        logic    busy;
        rob_id_t rob_id;
    } rat_entry_t;

endpackage

// File: rtl/arf_rat_read_port.sv
// One source-operand lookup: x0 forced to zero, optional forwarding of a same-cycle retire.
// Forwarding is compiled in only when ARF_RAT_BYPASS_EN is defined.
module arf_rat_read_port
    import arf_rat_pkg::*;
(
    input  arf_id_t    src_arf_id_i,
    input  rat_entry_t entry_i,
    input  reg_data_t  reg_data_i,
    input  logic       retire_i,
    input  rob_id_t    retire_rob_id_i,
    input  arf_id_t    retire_arf_id_i,
    input  reg_data_t  retire_reg_data_i,
    output logic       busy_o,
    output rob_id_t    rob_id_o,
    output reg_data_t  reg_data_o
);

    always_comb begin
        busy_o     = 1'b0;
        rob_id_o   = '0;
        reg_data_o = '0;
        if (src_arf_id_i != '0) begin
            busy_o     = entry_i.busy;
            rob_id_o   = entry_i.rob_id;
            reg_data_o = reg_data_i;
`ifdef ARF_RAT_BYPASS_EN
            // Only the retire of the current producer may resolve the operand early.
            if (retire_i && (retire_arf_id_i == src_arf_id_i) &&
                entry_i.busy && (entry_i.rob_id == retire_rob_id_i)) begin
                busy_o     = 1'b0;
                reg_data_o = retire_reg_data_i;
            end
`endif
        end
    end

`ifndef ARF_RAT_BYPASS_EN
    logic unused_retire;
    assign unused_retire = ^{retire_i, retire_rob_id_i, retire_arf_id_i, retire_reg_data_i};
`endif

endmodule

// File: rtl/arf_rat.sv
// Architectural register file with per-register busy/ROB-tag rename state.
// Define ARF_RAT_BYPASS_EN to forward same-cycle retires into the source lookups.
module arf_rat
    import arf_rat_pkg::*;
#(
    parameter int unsigned N_REGS = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      dispatch_valid,
    input  logic      dispatch_dst_valid,
    input  arf_id_t   dispatch_dst_arf_id,
    input  rob_id_t   dispatch_rob_id,
    input  arf_id_t   src1_arf_id,
    input  arf_id_t   src2_arf_id,
    output logic      src1_busy,
    output logic      src2_busy,
    output rob_id_t   src1_rob_id,
    output rob_id_t   src2_rob_id,
    output reg_data_t src1_reg_data,
    output reg_data_t src2_reg_data,
    input  logic      retire,
    input  rob_id_t   retire_rob_id,
    input  arf_id_t   retire_arf_id,
    input  reg_data_t retire_reg_data,
    input  logic      flush
);

    rat_entry_t rat_q  [N_REGS];
    rat_entry_t rat_d  [N_REGS];
    reg_data_t  data_q [N_REGS];
    reg_data_t  data_d [N_REGS];

    always_comb begin
        rat_d  = rat_q;
        data_d = data_q;
        if (retire && (retire_arf_id != '0)) begin
            data_d[retire_arf_id] = retire_reg_data;
            if (rat_q[retire_arf_id].busy && (rat_q[retire_arf_id].rob_id == retire_rob_id)) begin
                rat_d[retire_arf_id].busy = 1'b0;
            end
        end
        // Flush wins over everything on busy; a dispatch applied after the retire clear takes priority.
        if (flush) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                rat_d[i].busy = 1'b0;
            end
        end else if (dispatch_valid && dispatch_dst_valid && (dispatch_dst_arf_id != '0)) begin
            rat_d[dispatch_dst_arf_id].busy   = 1'b1;
            rat_d[dispatch_dst_arf_id].rob_id = dispatch_rob_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                rat_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rat_q  <= rat_d;
            data_q <= data_d;
        end
    end

    rat_entry_t src1_entry, src2_entry;
    reg_data_t  src1_data, src2_data;
    logic       retire_fwd;

    // Masking with rst keeps lookups at zero during the reset cycle, not only after it.
    always_comb begin
        src1_entry = rst ? '0 : rat_q[src1_arf_id];
        src2_entry = rst ? '0 : rat_q[src2_arf_id];
        src1_data  = rst ? '0 : data_q[src1_arf_id];
        src2_data  = rst ? '0 : data_q[src2_arf_id];
        retire_fwd = retire && !rst;
    end

    arf_rat_read_port u_rp1 (
        .src_arf_id_i      (src1_arf_id),
        .entry_i           (src1_entry),
        .reg_data_i        (src1_data),
        .retire_i          (retire_fwd),
        .retire_rob_id_i   (retire_rob_id),
        .retire_arf_id_i   (retire_arf_id),
        .retire_reg_data_i (retire_reg_data),
        .busy_o            (src1_busy),
        .rob_id_o          (src1_rob_id),
        .reg_data_o        (src1_reg_data)
    );

    arf_rat_read_port u_rp2 (
        .src_arf_id_i      (src2_arf_id),
        .entry_i           (src2_entry),
        .reg_data_i        (src2_data),
        .retire_i          (retire_fwd),
        .retire_rob_id_i   (retire_rob_id),
        .retire_arf_id_i   (retire_arf_id),
        .retire_reg_data_i (retire_reg_data),
        .busy_o            (src2_busy),
        .rob_id_o          (src2_rob_id),
        .reg_data_o        (src2_reg_data)
    );

endmodule

// File: doc/arf_rat.md
ARF_RAT -- requirements
Module: arf_rat

Interface
REQ-001 SHALL have parameter N_REGS, default 32, number of architectural integer registers; index width ARF_ID_WIDTH.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port dispatch_valid  in  1  dispatch handshake completed this cycle (ififo/ROB/IIQ/LSQ all ready).
REQ-005 SHALL have port dispatch_dst_valid  in  1  dispatched instr writes a destination.
REQ-006 SHALL have port dispatch_dst_arf_id  in  ARF_ID_WIDTH  destination register.
REQ-007 SHALL have port dispatch_rob_id  in  ROB_ID_WIDTH  ROB id allocated to the instr.
REQ-008 SHALL have ports src1_arf_id / src2_arf_id  in  ARF_ID_WIDTH  source lookups.
REQ-009 SHALL have ports src1_busy / src2_busy  out  1  source value pending in ROB.
REQ-010 SHALL have ports src1_rob_id / src2_rob_id  out  ROB_ID_WIDTH  producing ROB id, valid when busy.
REQ-011 SHALL have ports src1_reg_data / src2_reg_data  out  REG_DATA_WIDTH  architectural value, valid when not busy.
REQ-012 SHALL have ports retire  in  1, retire_rob_id  in  ROB_ID_WIDTH, retire_arf_id  in  ARF_ID_WIDTH, retire_reg_data  in  REG_DATA_WIDTH  ROB head commit.
REQ-013 SHALL have port flush  in  1  retire-time redirect (ROB retire_redirect_pc_valid).

Function
REQ-014 SHALL hold per register: reg_data, busy bit, rob_id tag.
REQ-015 SHALL treat register 0 as constant: reads return busy=0, data=0; writes/dispatches to 0 ignored.
REQ-016 SHALL provide src lookups combinationally (zero latency) from current state.
REQ-017 SHALL on dispatch_valid & dispatch_dst_valid & id!=0 set busy=1, tag=dispatch_rob_id at next edge.
REQ-018 SHALL on retire & id!=0 write retire_reg_data to reg_data at next edge, regardless of tag.
REQ-019 SHALL on retire clear busy only if busy=1 and tag==retire_rob_id; else busy/tag unchanged (younger producer pending).
REQ-020 SHALL give dispatch priority over retire clear on the same register same cycle: busy=1, new tag; data still written.
REQ-021 SHALL on flush clear every busy bit at next edge; tags keep stale values.
REQ-022 SHALL drop a dispatch coinciding with flush; a coinciding retire still writes data.
REQ-023 SHALL be always ready; no backpressure outputs.

Reset
REQ-024 SHALL on rst at a rising edge set all reg_data=0, busy=0, tag=0; rst overrides dispatch, retire, flush.
REQ-025 SHALL drive, during/after reset, src*_busy=0, src*_rob_id=0, src*_reg_data=0.

Configuration
REQ-026 SHALL, with ARF_RAT_BYPASS_EN defined, forward same-cycle retire to lookups: if retire, retire_arf_id==srcN_arf_id!=0, busy=1 and tag==retire_rob_id, then srcN_busy=0, srcN_reg_data=retire_reg_data.
REQ-027 SHALL, without ARF_RAT_BYPASS_EN, show retire effects only from the cycle after the edge.

Structure
REQ-028 SHALL use arf_id_t, rob_id_t, reg_data_t from the global defines header; add rat_entry_t {busy, rob_id} there.
REQ-029 SHALL implement lookup plus optional bypass as sub-module arf_rat_read_port, instantiated twice.

Verification
REQ-030 Dispatch x5 tag 3, read src1=x5 next cycle -> busy=1, rob_id=3.
REQ-031 Retire rob 3 x5 data 0xDEADBEEF -> next cycle busy=0, data=0xDEADBEEF; with bypass, same cycle.
REQ-032 Dispatch x7 tag 2, then tag 6; retire rob 2 x7 data 0x11 -> busy=1, rob_id=6, data later 0x11 on retire 6.
REQ-033 Dispatch x9 tag 4 same cycle as retire rob 1 x9 (tag 1) -> busy=1, rob_id=4.
REQ-034 x1..x3 busy, flush with dispatch x4 -> all busy=0, x4 not busy.
REQ-035 Dispatch/retire x0 data 0x55 -> src=x0 busy=0, data=0; rst mid-sequence -> all outputs 0.
